// File: rtl/alu_ctrl_pkg.sv
// Shared codes for the ALU controller / iterative multiply-divide unit.
// Optional feature macro: MDU_DIV_EN (enables DIV/DIVU in the MDU).
package alu_ctrl_pkg;

  // Main-decoder ALUOp encodings
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_SLT   = 3'b100;

  // R-type funct codes
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  // ALU control words
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

  // Values match funct[1:0] of the MDU start codes
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_t;

  function automatic logic [3:0] alu_ctrl_decode(input logic [2:0] aluop,
                                                 input logic [5:0] funct);
    logic [3:0] ctrl;
    ctrl = CTRL_ADD;
    case (aluop)
      ALUOP_ADD: ctrl = CTRL_ADD;
      ALUOP_SUB: ctrl = CTRL_SUB;
      ALUOP_SLT: ctrl = CTRL_SLT;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:  ctrl = CTRL_ADD;
          FN_SUB:  ctrl = CTRL_SUB;
          FN_AND:  ctrl = CTRL_AND;
          FN_OR:   ctrl = CTRL_OR;
          FN_SLT:  ctrl = CTRL_SLT;
          default: ctrl = CTRL_ADD;
        endcase
      end
      default: ctrl = CTRL_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide engine: one result bit per cycle, sign fixup in FIX.
// Divider datapath only exists when MDU_DIV_EN is defined.
module mdu_iter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  mdu_op_t           i_op,
  input  logic [DATA_W-1:0] i_src1,
  input  logic [DATA_W-1:0] i_src2,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  mdu_state_t              r_state;
  mdu_state_t              w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_neg_p;   // product / quotient must be negated
  logic [DATA_W-1:0]       r_m;       // multiplicand or divisor magnitude
  logic [DATA_W-1:0]       r_hi;      // partial product high / remainder
  logic [DATA_W-1:0]       r_lo;      // multiplier / dividend, shifting out
  logic                    w_signed;
  logic                    w_neg1;
  logic                    w_neg2;
  logic [DATA_W-1:0]       w_mag1;
  logic [DATA_W-1:0]       w_mag2;
  logic [DATA_W:0]         w_sum;
  logic [2*DATA_W-1:0]     w_prod;
`ifdef MDU_DIV_EN
  logic                    r_div;
  logic                    r_dz;
  logic                    r_neg_r;   // remainder takes the dividend's sign
  logic                    w_is_div;
  logic                    w_dz;
  logic [DATA_W:0]         w_shift;
  logic                    w_ge;
  logic [DATA_W-1:0]       w_sub;
`endif

  // Operand magnitudes and sign flags at start
  always_comb begin
    w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    w_neg1   = w_signed & i_src1[DATA_W-1];
    w_neg2   = w_signed & i_src2[DATA_W-1];
    w_mag1   = w_neg1 ? -i_src1 : i_src1;
    w_mag2   = w_neg2 ? -i_src2 : i_src2;
`ifdef MDU_DIV_EN
    w_is_div = (i_op == OP_DIV) || (i_op == OP_DIVU);
    w_dz     = w_is_div && (i_src2 == '0);
`endif
  end

  // Per-cycle shift-add and restoring-subtract steps
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
`ifdef MDU_DIV_EN
    w_shift = {r_hi, r_lo[DATA_W-1]};
    w_ge    = (w_shift >= {1'b0, r_m});
    w_sub   = w_shift[DATA_W-1:0] - r_m;
`endif
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
`ifdef MDU_DIV_EN
        if (i_start) w_next = w_dz ? ST_FIX : ST_RUN;
`else
        if (i_start) w_next = ST_RUN;
`endif
      end
      ST_RUN:  if (r_cnt == CNT_W'(DATA_W - 1)) w_next = ST_FIX;
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_busy = (r_state != ST_IDLE);
    o_done = (r_state == ST_FIX);
  end

  // RUN-cycle counter; parks at DATA_W in FIX, cleared otherwise
  always_ff @(posedge i_clk) begin
    if (i_rst)                  r_cnt <= '0;
    else if (r_state == ST_RUN) r_cnt <= r_cnt + CNT_W'(1);
    else                        r_cnt <= '0;
  end

  // Operand latch and iterative datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_neg_p <= 1'b0;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MDU_DIV_EN
      r_div   <= 1'b0;
      r_dz    <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else if (r_state == ST_IDLE && i_start) begin
      r_neg_p <= w_neg1 ^ w_neg2;
      r_m     <= w_mag2;
      r_hi    <= '0;
      r_lo    <= w_mag1;
`ifdef MDU_DIV_EN
      r_div   <= w_is_div;
      r_dz    <= w_dz;
      r_neg_r <= w_neg1;
`endif
    end else if (r_state == ST_RUN) begin
`ifdef MDU_DIV_EN
      if (r_div) begin
        if (w_ge) begin
          r_hi <= w_sub;
          r_lo <= {r_lo[DATA_W-2:0], 1'b1};
        end else begin
          r_hi <= w_shift[DATA_W-1:0];
          r_lo <= {r_lo[DATA_W-2:0], 1'b0};
        end
      end else
`endif
      begin
        r_hi <= w_sum[DATA_W:1];
        r_lo <= {w_sum[0], r_lo[DATA_W-1:1]};
      end
    end
  end

  // Sign fixup; divide-by-zero keeps r_lo = |dividend| since RUN was skipped
  always_comb begin
    w_prod = r_neg_p ? -{r_hi, r_lo} : {r_hi, r_lo};
    o_hi   = w_prod[2*DATA_W-1:DATA_W];
    o_lo   = w_prod[DATA_W-1:0];
`ifdef MDU_DIV_EN
    if (r_dz) begin
      o_hi = r_neg_r ? -r_lo : r_lo;
      o_lo = '1;
    end else if (r_div) begin
      o_hi = r_neg_r ? -r_hi : r_hi;
      o_lo = r_neg_p ? -r_lo : r_lo;
    end
`endif
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decode, MDU start/interlock, architectural HI/LO and MFHI/MFLO mux.
// Optional feature macro: MDU_DIV_EN (DIV/DIVU supported; otherwise illegal funct).
module alu_ctrl_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [2:0]        ALUOp_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic [DATA_W-1:0] hilo_o,
  output logic              hilo_sel_o,
  output logic              busy_o,
  output logic              stall_o,
  output logic              done_o,
  output logic              ill_o
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              w_rdec;
  logic              w_alu_fn;
  logic              w_mul_fn;
  logic              w_div_fn;
  logic              w_mf_fn;
  logic              w_start_fn;
  logic              w_mdu_fn;
  logic              w_start;
  logic              w_busy;
  logic              w_done;
  logic [DATA_W-1:0] w_mdu_hi;
  logic [DATA_W-1:0] w_mdu_lo;
  logic [DATA_W-1:0] w_hi_cur;
  logic [DATA_W-1:0] w_lo_cur;

  // Funct classification for a valid R-type instruction
  always_comb begin
    w_rdec     = valid_i && (ALUOp_i == ALUOP_RTYPE);
    w_alu_fn   = funct_i inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    w_mul_fn   = funct_i inside {FN_MULT, FN_MULTU};
`ifdef MDU_DIV_EN
    w_div_fn   = funct_i inside {FN_DIV, FN_DIVU};
`else
    w_div_fn   = 1'b0;
`endif
    w_mf_fn    = funct_i inside {FN_MFHI, FN_MFLO};
    w_start_fn = w_mul_fn | w_div_fn;
    w_mdu_fn   = w_start_fn | w_mf_fn;
  end

  // ALU control, start, interlock and illegal-funct pulse
  always_comb begin
    ALUCtrl_o = CTRL_W'(alu_ctrl_decode(ALUOp_i, funct_i));
    w_start   = w_rdec & w_start_fn & ~w_busy;
    stall_o   = w_busy | (w_rdec & w_mdu_fn & w_busy);
    ill_o     = w_rdec & ~(w_alu_fn | w_mdu_fn) & ~rst_i;
    busy_o    = w_busy;
    done_o    = w_done;
  end

  mdu_iter #(
    .DATA_W(DATA_W)
  ) u_mdu (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_start (w_start),
    .i_op    (mdu_op_t'(funct_i[1:0])),
    .i_src1  (src1_i),
    .i_src2  (src2_i),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_hi    (w_mdu_hi),
    .o_lo    (w_mdu_lo)
  );

  // Architectural HI/LO, written in the done cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      r_hi <= w_mdu_hi;
      r_lo <= w_mdu_lo;
    end
  end

  // MFHI/MFLO read mux; forwards the result being written in the done cycle
  always_comb begin
    w_hi_cur   = w_done ? w_mdu_hi : r_hi;
    w_lo_cur   = w_done ? w_mdu_lo : r_lo;
    hilo_o     = '0;
    if (w_rdec && w_mf_fn) hilo_o = (funct_i == FN_MFHI) ? w_hi_cur : w_lo_cur;
    hilo_sel_o = w_rdec & w_mf_fn & ~w_busy;
  end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench for alu_ctrl_mdu (DATA_W = 32), random ops vs arithmetic model.
module tb_alu_ctrl_mdu;

  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_MULT = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010;
`ifdef MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [2:0]  aluop = '0;
  logic [5:0]  funct = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [3:0]  alu_ctrl;
  logic [31:0] hilo;
  logic        hilo_sel, busy, stall, done, ill;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  alu_ctrl_mdu #(.DATA_W(32), .CTRL_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ALUOp_i(aluop), .funct_i(funct),
    .src1_i(src1), .src2_i(src2), .ALUCtrl_o(alu_ctrl), .hilo_o(hilo),
    .hilo_sel_o(hilo_sel), .busy_o(busy), .stall_o(stall), .done_o(done), .ill_o(ill)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_ctrl(input logic [2:0] op, input logic [5:0] f);
    if (op == 3'b001) return 4'b0110;
    if (op == 3'b100) return 4'b0111;
    if (op == 3'b010) begin
      if (f == F_SUB) return 4'b0110;
      if (f == F_AND) return 4'b0000;
      if (f == F_OR)  return 4'b0001;
      if (f == F_SLT) return 4'b0111;
    end
    return 4'b0010;
  endfunction

  function automatic bit fn_known(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_SLT) ||
           (f == F_MULT) || (f == F_MULTU) || (f == F_MFHI) || (f == F_MFLO) ||
           (DIV_ON && ((f == F_DIV) || (f == F_DIVU)));
  endfunction

  function automatic bit fn_starts(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (DIV_ON && ((f == F_DIV) || (f == F_DIVU)));
  endfunction

  // Reference arithmetic from the instruction definitions
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0; lo = '0;
    case (f)
      F_MULTU: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      F_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      F_DIVU:  if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
               else begin lo = a / b; hi = a % b; end
      F_DIV:   if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
               else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      default: ;
    endcase
  endtask

  // Issue one MDU op at cycle 0 and report the cycle done_o was seen (-1: timeout)
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit busy_all);
    @(negedge clk);
    valid = 1'b1; aluop = 3'b010; funct = f; src1 = a; src2 = b;
    @(negedge clk);
    valid = 1'b0;
    lat = -1; busy_all = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      #1;
      if (busy !== 1'b1) busy_all = 1'b0;
      if (done === 1'b1) begin lat = c; break; end
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo,
                           output logic sel, output logic bsy);
    @(negedge clk);
    valid = 1'b1; aluop = 3'b010; funct = F_MFHI;
    #1; hi = hilo; sel = hilo_sel; bsy = busy;
    funct = F_MFLO;
    #1; lo = hilo; sel = sel & hilo_sel;
    valid = 1'b0; funct = '0;
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo; logic sel, bsy;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL reset_flags busy=%b done=%b stall=%b exp 0/0/0", busy, done, stall);
    end
    rst = 1'b0;
    read_hilo(hi, lo, sel, bsy);
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin
      failures++; $display("FAIL reset_hilo hi=%h lo=%h exp 0/0", hi, lo);
    end
    checks++; if (sel !== 1'b1 || bsy !== 1'b0) begin
      failures++; $display("FAIL reset_sel sel=%b busy=%b exp 1/0", sel, bsy);
    end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_multu_spec();
    int lat; bit ball; logic [31:0] hi, lo; logic sel, bsy;
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'h2, lat, ball);
    checks++; if (lat != 33 || !ball) begin
      failures++; $display("FAIL multu_latency lat=%0d busy_all=%0d exp 33/1", lat, ball);
    end
    read_hilo(hi, lo, sel, bsy);
    checks++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL multu_result hi=%h lo=%h exp 00000001/fffffffe", hi, lo);
    end
    checks++; if (bsy !== 1'b0 || sel !== 1'b1) begin
      failures++; $display("FAIL multu_busy_end busy=%b sel=%b exp 0/1", bsy, sel);
    end
    m_hi = 32'h1; m_lo = 32'hFFFF_FFFE;
  endtask

  task automatic test_mult_spec();
    int lat; bit ball; logic [31:0] hi, lo; logic sel, bsy;
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd5, lat, ball);
    checks++; if (lat != 33) begin
      failures++; $display("FAIL mult_latency lat=%0d exp 33", lat);
    end
    read_hilo(hi, lo, sel, bsy);
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1 || sel !== 1'b1) begin
      failures++; $display("FAIL mult_mflo hi=%h lo=%h sel=%b exp ffffffff/fffffff1/1", hi, lo, sel);
    end
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFF1;
  endtask

  task automatic test_alu_decode();
    logic [2:0] t_op  [5] = '{3'b010, 3'b010, 3'b010, 3'b001, 3'b100};
    logic [5:0] t_fn  [5] = '{F_OR, F_SLT, F_AND, 6'b000000, 6'b000000};
    logic [3:0] t_exp [5] = '{4'b0001, 4'b0111, 4'b0000, 4'b0110, 4'b0111};
    logic [5:0] codes [11] = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_MULT, F_MULTU,
                               F_DIV, F_DIVU, F_MFHI, F_MFLO};
    bit v, mf; logic [31:0] eh;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); valid = 1'b0; aluop = t_op[i]; funct = t_fn[i]; #1;
      checks++; if (alu_ctrl !== t_exp[i]) begin
        failures++; $display("FAIL decode_fixed op=%b fn=%b got=%b exp=%b", t_op[i], t_fn[i], alu_ctrl, t_exp[i]);
      end
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      aluop = 3'($urandom_range(0, 7));
      funct = ($urandom_range(0, 1) == 1) ? codes[$urandom_range(0, 10)] : 6'($urandom);
      v = 1'($urandom);
      if (v && aluop == 3'b010 && fn_starts(funct)) v = 1'b0;
      valid = v;
      #1;
      mf = v && aluop == 3'b010 && (funct == F_MFHI || funct == F_MFLO);
      eh = mf ? ((funct == F_MFHI) ? m_hi : m_lo) : 32'h0;
      checks++; if (alu_ctrl !== exp_ctrl(aluop, funct)) begin
        failures++; $display("FAIL decode_ctrl op=%b fn=%b got=%b exp=%b", aluop, funct, alu_ctrl, exp_ctrl(aluop, funct));
      end
      checks++; if (ill !== (v && aluop == 3'b010 && !fn_known(funct))) begin
        failures++; $display("FAIL decode_ill op=%b fn=%b v=%b got=%b", aluop, funct, v, ill);
      end
      checks++; if (hilo_sel !== mf || hilo !== eh || stall !== 1'b0) begin
        failures++; $display("FAIL decode_hilo fn=%b sel=%b hilo=%h stall=%b exp %b/%h/0", funct, hilo_sel, hilo, stall, mf, eh);
      end
    end
    @(negedge clk); valid = 1'b0;
  endtask

  task automatic test_div();
    logic [31:0] hi, lo; logic sel, bsy;
`ifdef MDU_DIV_EN
    int lat; bit ball;
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, lat, ball);
    read_hilo(hi, lo, sel, bsy);
    checks++; if (lat != 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL div_neg lat=%0d hi=%h lo=%h exp 33/ffffffff/fffffffd", lat, hi, lo);
    end
    run_op(F_DIVU, 32'd9, 32'd0, lat, ball);
    read_hilo(hi, lo, sel, bsy);
    checks++; if (lat != 1 || hi !== 32'd9 || lo !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL divu_zero lat=%0d hi=%h lo=%h exp 1/00000009/ffffffff", lat, hi, lo);
    end
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, ball);
    read_hilo(hi, lo, sel, bsy);
    checks++; if (lat != 33 || hi !== 32'h0 || lo !== 32'h8000_0000) begin
      failures++; $display("FAIL div_ovf lat=%0d hi=%h lo=%h exp 33/00000000/80000000", lat, hi, lo);
    end
    m_hi = hi; m_lo = lo;
`else
    @(negedge clk);
    valid = 1'b1; aluop = 3'b010; funct = F_DIV; src1 = 32'd100; src2 = 32'd7;
    #1;
    checks++; if (ill !== 1'b1 || alu_ctrl !== 4'b0010) begin
      failures++; $display("FAIL div_disabled_ill ill=%b ctrl=%b exp 1/0010", ill, alu_ctrl);
    end
    @(negedge clk); valid = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin
      failures++; $display("FAIL div_disabled_start busy=%b exp 0", busy);
    end
    read_hilo(hi, lo, sel, bsy);
    checks++; if (hi !== m_hi || lo !== m_lo) begin
      failures++; $display("FAIL div_disabled_hilo hi=%h lo=%h exp %h/%h", hi, lo, m_hi, m_lo);
    end
`endif
  endtask

  task automatic test_random_ops();
    logic [5:0] ops [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    logic [5:0] f; logic [31:0] a, b, eh, el, hi, lo; logic sel, bsy;
    int lat, elat; bit ball;
    for (int i = 0; i < 24; i++) begin
      f = ops[$urandom_range(0, DIV_ON ? 3 : 1)];
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 10)) - 32'd5; end
        default: ;
      endcase
      model(f, a, b, eh, el);
      elat = ((f == F_DIV || f == F_DIVU) && b == 0) ? 1 : 33;
      run_op(f, a, b, lat, ball);
      read_hilo(hi, lo, sel, bsy);
      checks++; if (lat != elat || !ball) begin
        failures++; $display("FAIL rand_latency fn=%b a=%h b=%h lat=%0d busy_all=%0d exp %0d", f, a, b, lat, ball, elat);
      end
      checks++; if (hi !== eh || lo !== el) begin
        failures++; $display("FAIL rand_result fn=%b a=%h b=%h hi=%h lo=%h exp %h/%h", f, a, b, hi, lo, eh, el);
      end
      checks++; if (sel !== 1'b1 || bsy !== 1'b0) begin
        failures++; $display("FAIL rand_idle sel=%b busy=%b exp 1/0", sel, bsy);
      end
      m_hi = eh; m_lo = el;
    end
  endtask

  task automatic test_stall_mfhi();
    logic [31:0] a, b, eh, el; bit seen;
    a = $urandom; b = $urandom;
    model(F_MULT, a, b, eh, el);
    @(negedge clk); valid = 1'b1; aluop = 3'b010; funct = F_MULT; src1 = a; src2 = b;
    @(negedge clk); valid = 1'b0;
    @(negedge clk);
    @(negedge clk); valid = 1'b1; funct = F_MFHI;
    seen = 1'b0;
    for (int c = 3; c <= 60; c++) begin
      #1;
      checks++; if (stall !== 1'b1) begin
        failures++; $display("FAIL stall_held cycle=%0d stall=%b exp 1", c, stall);
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        checks++; if (c != 33 || hilo !== eh) begin
          failures++; $display("FAIL stall_forward cycle=%0d hilo=%h exp 33/%h", c, hilo, eh);
        end
        break;
      end
      checks++; if (hilo_sel !== 1'b0) begin
        failures++; $display("FAIL stall_sel cycle=%0d sel=%b exp 0", c, hilo_sel);
      end
      @(negedge clk);
    end
    checks++; if (!seen) begin
      failures++; $display("FAIL stall_timeout done seen=0 exp 1");
    end
    @(negedge clk); #1;
    checks++; if (stall !== 1'b0 || hilo_sel !== 1'b1 || hilo !== eh) begin
      failures++; $display("FAIL stall_release stall=%b sel=%b hilo=%h exp 0/1/%h", stall, hilo_sel, hilo, eh);
    end
    valid = 1'b0;
    m_hi = eh; m_lo = el;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, eh, el, hi, lo; logic sel, bsy; int lat;
    a = $urandom; b = $urandom;
    model(F_MULT, a, b, eh, el);
    @(negedge clk); valid = 1'b1; aluop = 3'b010; funct = F_MULT; src1 = a; src2 = b;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      valid = (c == 2); src1 = ~a; src2 = b + 32'd3;
      #1;
      if (c == 2) begin
        checks++; if (stall !== 1'b1) begin
          failures++; $display("FAIL b2b_stall stall=%b exp 1", stall);
        end
      end
      if (done === 1'b1) begin
        lat = c;
        valid = 1'b1; #1;
        checks++; if (stall !== 1'b1) begin
          failures++; $display("FAIL b2b_done_stall stall=%b exp 1", stall);
        end
        break;
      end
    end
    checks++; if (lat != 33) begin
      failures++; $display("FAIL b2b_latency lat=%0d exp 33", lat);
    end
    @(negedge clk); valid = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin
      failures++; $display("FAIL b2b_no_restart busy=%b exp 0", busy);
    end
    read_hilo(hi, lo, sel, bsy);
    checks++; if (hi !== eh || lo !== el) begin
      failures++; $display("FAIL b2b_result hi=%h lo=%h exp %h/%h", hi, lo, eh, el);
    end
    m_hi = eh; m_lo = el;
  endtask

  task automatic test_reset_midop();
    logic [31:0] hi, lo; logic sel, bsy; bit saw_done;
    @(negedge clk); valid = 1'b1; aluop = 3'b010; funct = F_MULT;
    src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF1;
    for (int c = 1; c < 10; c++) begin @(negedge clk); valid = 1'b0; end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_busy busy=%b exp 0", busy);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin
      failures++; $display("FAIL rstmid_done saw_done=1 exp 0");
    end
    read_hilo(hi, lo, sel, bsy);
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin
      failures++; $display("FAIL rstmid_hilo hi=%h lo=%h exp 0/0", hi, lo);
    end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_ill();
    @(negedge clk); valid = 1'b1; aluop = 3'b010; funct = 6'b111111; #1;
    checks++; if (ill !== 1'b1 || alu_ctrl !== 4'b0010) begin
      failures++; $display("FAIL ill_pulse ill=%b ctrl=%b exp 1/0010", ill, alu_ctrl);
    end
    @(negedge clk); valid = 1'b0; #1;
    checks++; if (ill !== 1'b0) begin
      failures++; $display("FAIL ill_novalid ill=%b exp 0", ill);
    end
    @(negedge clk); valid = 1'b1; aluop = 3'b000; #1;
    checks++; if (ill !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL ill_nonrtype ill=%b busy=%b exp 0/0", ill, busy);
    end
    valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_multu_spec();
    test_mult_spec();
    test_alu_decode();
    test_div();
    test_random_ops();
    test_stall_mfhi();
    test_back_to_back();
    test_reset_midop();
    test_ill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
